// File: rtl/shift_register_universal.sv
// shift_register_universal
//   WIDTH-bit universal register with clock enable, parallel load, logical shift
//   and rotate in both directions, synchronous clear, and an autonomous serialiser
//   that loads a word on start and shifts it out on sout, one bit per enabled clock.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   en         clock enable; 0 freezes q, FSM state and bit counter
//   mode[2:0]  manual operation select (only honoured while idle)
//   d          parallel load / serialiser source word
//   sin_left   serial input entering the MSB on shift right
//   sin_right  serial input entering the LSB on shift left
//   start      one-cycle request to load d and serialise it
//   dir        serialise order: 0 = MSB first, 1 = LSB first
//   q          register contents
//   sout       serial output, selected by the latched direction
//   busy       high while the serialiser is shifting
//   done       one-cycle pulse when serialisation completes
module shift_register_universal #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_left,
    input  logic             sin_right,
    input  logic             start,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROTL  = 3'b011;
    localparam logic [2:0] MODE_ROTR  = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            dir_r;

    // Register bank and serialiser FSM share one process because the FSM owns q
    // while shifting; manual modes only act in IDLE. DONE always falls back to
    // IDLE on the next clock, independent of en, so the done pulse is one clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q     <= RESET_VALUE;
            state <= IDLE;
            count <= '0;
            dir_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        if (start) begin
                            q     <= d;
                            dir_r <= dir;
                            count <= '0;
                            state <= SHIFT;
                        end else begin
                            case (mode)
                                MODE_SHL: begin
                                    q     <= {q[WIDTH-2:0], sin_right};
                                    dir_r <= 1'b0;
                                end
                                MODE_SHR: begin
                                    q     <= {sin_left, q[WIDTH-1:1]};
                                    dir_r <= 1'b1;
                                end
                                MODE_ROTL: begin
                                    q     <= {q[WIDTH-2:0], q[WIDTH-1]};
                                    dir_r <= 1'b0;
                                end
                                MODE_ROTR: begin
                                    q     <= {q[0], q[WIDTH-1:1]};
                                    dir_r <= 1'b1;
                                end
                                MODE_LOAD:  q <= d;
                                MODE_CLEAR: q <= '0;
                                default:    q <= q;
                            endcase
                        end
                    end
                end
                SHIFT: begin
                    // Zero fill, so q is all zeros once every bit has left.
                    if (en) begin
                        if (dir_r) begin
                            q <= {1'b0, q[WIDTH-1:1]};
                        end else begin
                            q <= {q[WIDTH-2:0], 1'b0};
                        end
                        count <= count + CW'(1);
                        if (count == LAST_COUNT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sout = dir_r ? q[0] : q[WIDTH-1];
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_register_universal.sv
// tb_shift_register_universal
//   Self-checking bench for shift_register_universal (WIDTH=8, nonzero reset value).
//   Expected register values and serial bits are queued when stimulus is driven and
//   popped when the design produces them.
module tb_shift_register_universal;

    localparam int               WIDTH = 8;
    localparam logic [WIDTH-1:0] RV    = 8'h3C;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHL   = 3'b001;
    localparam logic [2:0] M_SHR   = 3'b010;
    localparam logic [2:0] M_ROTL  = 3'b011;
    localparam logic [2:0] M_ROTR  = 3'b100;
    localparam logic [2:0] M_LOAD  = 3'b101;
    localparam logic [2:0] M_CLEAR = 3'b110;
    localparam logic [2:0] M_RSVD  = 3'b111;

    logic             clock = 1'b0;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_left;
    logic             sin_right;
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    int checkCount = 0;
    int passCount  = 0;

    logic [WIDTH-1:0] expQ[$];
    logic             expBits[$];

    shift_register_universal #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .sin_left  (sin_left),
        .sin_right (sin_right),
        .start     (start),
        .dir       (dir),
        .q         (q),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Advance one clock and sample just after the rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Load a value, then assert reset between edges and hold it across clocks.
    task automatic test_reset;
        reset = 1'b1; en = 1'b0; start = 1'b0; mode = M_HOLD; d = '0;
        dir = 1'b0; sin_left = 1'b0; sin_right = 1'b0;
        #12;
        @(negedge clock);
        reset = 1'b0;
        checkCount++;
        if (q !== RV) $display("[TB] FAIL reset.initial_q got %h want %h", q, RV);
        else passCount++;
        en = 1'b1; mode = M_LOAD; d = 8'h5A;
        tick;
        mode = M_HOLD;
        checkCount++;
        if (q !== 8'h5A) $display("[TB] FAIL reset.preload got %h want %h", q, 8'h5A);
        else passCount++;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkCount++;
        if (q !== RV || busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL reset.async got q=%h busy=%b done=%b want q=%h busy=0 done=0", q, busy, done, RV);
        else passCount++;
        mode = M_LOAD; d = 8'hFF; start = 1'b1;
        tick;
        tick;
        checkCount++;
        if (q !== RV || busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL reset.held got q=%h busy=%b done=%b want q=%h busy=0 done=0", q, busy, done, RV);
        else passCount++;
        start = 1'b0; mode = M_HOLD;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Manual load/shift/clear, hold and reserved modes, en freeze, and sout direction.
    task automatic test_shifts;
        logic [2:0]       mt [8] = '{M_LOAD, M_SHL, M_SHR, M_HOLD, M_SHL, M_RSVD, M_SHR, M_CLEAR};
        logic             et [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic             lt [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic             rt [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [WIDTH-1:0] qt [8] = '{8'hA5, 8'h4B, 8'h25, 8'h25, 8'h25, 8'h25, 8'h92, 8'h00};
        logic             st [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [WIDTH-1:0] wantQ;
        logic             wantS;
        d = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            mode = mt[i]; en = et[i]; sin_left = lt[i]; sin_right = rt[i];
            expQ.push_back(qt[i]);
            expBits.push_back(st[i]);
            tick;
            wantQ = expQ.pop_front();
            wantS = expBits.pop_front();
            checkCount++;
            if (q !== wantQ || sout !== wantS)
                $display("[TB] FAIL shifts.step%0d got q=%h sout=%b want q=%h sout=%b", i, q, sout, wantQ, wantS);
            else passCount++;
        end
        en = 1'b1; mode = M_HOLD;
    endtask

    // Rotate left a full turn and back to the start value, then rotate right once.
    task automatic test_rotate;
        logic [WIDTH-1:0] model;
        logic [WIDTH-1:0] wantQ;
        en = 1'b1; d = 8'h81; mode = M_LOAD;
        model = 8'h81;
        expQ.push_back(model);
        tick;
        for (int i = 0; i < 8; i++) begin
            wantQ = expQ.pop_front();
            checkCount++;
            if (q !== wantQ) $display("[TB] FAIL rotate.rotl%0d got %h want %h", i, q, wantQ);
            else passCount++;
            mode = M_ROTL;
            model = (model << 1) | (model >> (WIDTH - 1));
            expQ.push_back(model);
            tick;
        end
        wantQ = expQ.pop_front();
        checkCount++;
        if (q !== 8'h81 || wantQ !== 8'h81) $display("[TB] FAIL rotate.full_turn got %h want %h", q, 8'h81);
        else passCount++;
        mode = M_ROTR;
        tick;
        mode = M_HOLD;
        checkCount++;
        if (q !== 8'hC0) $display("[TB] FAIL rotate.rotr got %h want %h", q, 8'hC0);
        else passCount++;
    endtask

    // Serialise 0xC3 MSB-first then LSB-first; mode=clear alongside start checks start priority.
    task automatic test_serialise;
        logic [WIDTH-1:0] word;
        int               busyCycles;
        for (int dv = 0; dv < 2; dv++) begin
            word = 8'hC3;
            for (int i = 0; i < WIDTH; i++)
                expBits.push_back(dv ? word[i] : word[WIDTH-1-i]);
            en = 1'b1; d = word; dir = dv[0]; mode = M_CLEAR; start = 1'b1;
            tick;
            start = 1'b0; mode = M_HOLD; d = 8'hFF;
            busyCycles = 0;
            for (int c = 0; c < 3 * WIDTH && done !== 1'b1; c++) begin
                if (busy === 1'b1) begin
                    checkCount++;
                    if (expBits.size() == 0)
                        $display("[TB] FAIL serialise.extra_bit dir=%0d got sout=%b want no bit", dv, sout);
                    else if (sout !== expBits[0])
                        $display("[TB] FAIL serialise.bit%0d dir=%0d got %b want %b", busyCycles, dv, sout, expBits[0]);
                    else passCount++;
                    if (expBits.size() > 0) void'(expBits.pop_front());
                    busyCycles++;
                end
                tick;
            end
            checkCount++;
            if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h00)
                $display("[TB] FAIL serialise.done dir=%0d got done=%b busy=%b q=%h want done=1 busy=0 q=00", dv, done, busy, q);
            else passCount++;
            checkCount++;
            if (busyCycles != WIDTH || expBits.size() != 0)
                $display("[TB] FAIL serialise.length dir=%0d got %0d cycles left=%0d want %0d left=0", dv, busyCycles, expBits.size(), WIDTH);
            else passCount++;
            expBits.delete();
            tick;
            checkCount++;
            if (done !== 1'b0) $display("[TB] FAIL serialise.done_pulse dir=%0d got done=%b want 0", dv, done);
            else passCount++;
        end
    endtask

    // Drop en for three clocks once three bits have gone; order holds and done slips by three.
    task automatic test_stall;
        logic [WIDTH-1:0] word;
        int               busyCycles;
        int               consumed;
        int               stalled;
        word = 8'hB4;
        for (int i = 0; i < WIDTH; i++) expBits.push_back(word[WIDTH-1-i]);
        en = 1'b1; d = word; dir = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        busyCycles = 0; consumed = 0; stalled = 0;
        for (int c = 0; c < 4 * WIDTH && done !== 1'b1; c++) begin
            if (busy === 1'b1) begin
                checkCount++;
                if (expBits.size() == 0)
                    $display("[TB] FAIL stall.extra_bit got sout=%b want no bit", sout);
                else if (sout !== expBits[0])
                    $display("[TB] FAIL stall.cycle%0d got %b want %b", busyCycles, sout, expBits[0]);
                else passCount++;
                if (consumed == 3 && stalled < 3) begin
                    en = 1'b0;
                    stalled++;
                end else begin
                    en = 1'b1;
                    if (expBits.size() > 0) void'(expBits.pop_front());
                    consumed++;
                end
                busyCycles++;
            end
            tick;
        end
        en = 1'b1;
        checkCount++;
        if (done !== 1'b1 || q !== 8'h00 || busyCycles != WIDTH + 3)
            $display("[TB] FAIL stall.done got done=%b q=%h cycles=%0d want done=1 q=00 cycles=%0d", done, q, busyCycles, WIDTH + 3);
        else passCount++;
        expBits.delete();
        tick;
    endtask

    // Start while busy and in DONE is dropped; reset mid-stream aborts with no done pulse.
    task automatic test_collisions;
        logic [WIDTH-1:0] word;
        int               busyCycles;
        int               doneSeen;
        word = 8'hC3;
        for (int i = 0; i < WIDTH; i++) expBits.push_back(word[i]);
        en = 1'b1; d = word; dir = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        busyCycles = 0;
        for (int c = 0; c < 3 * WIDTH && done !== 1'b1; c++) begin
            start = 1'b0;
            if (busy === 1'b1) begin
                checkCount++;
                if (expBits.size() == 0)
                    $display("[TB] FAIL collide.extra_bit got sout=%b want no bit", sout);
                else if (sout !== expBits[0])
                    $display("[TB] FAIL collide.bit%0d got %b want %b", busyCycles, sout, expBits[0]);
                else passCount++;
                if (expBits.size() > 0) void'(expBits.pop_front());
                if (busyCycles == 2) begin
                    start = 1'b1; d = 8'h00; dir = 1'b0;
                end
                busyCycles++;
            end
            tick;
        end
        checkCount++;
        if (done !== 1'b1 || busyCycles != WIDTH)
            $display("[TB] FAIL collide.length got done=%b cycles=%0d want done=1 cycles=%0d", done, busyCycles, WIDTH);
        else passCount++;
        expBits.delete();
        start = 1'b1; d = 8'hFF;
        tick;
        start = 1'b0;
        checkCount++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h00)
            $display("[TB] FAIL collide.start_in_done got busy=%b done=%b q=%h want busy=0 done=0 q=00", busy, done, q);
        else passCount++;

        word = 8'hC3;
        en = 1'b1; d = word; dir = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        checkCount++;
        if (busy !== 1'b1 || sout !== word[WIDTH-5])
            $display("[TB] FAIL collide.fifth_bit got busy=%b sout=%b want busy=1 sout=%b", busy, sout, word[WIDTH-5]);
        else passCount++;
        #2 reset = 1'b1;
        #1;
        checkCount++;
        if (q !== RV || busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL collide.reset_abort got q=%h busy=%b done=%b want q=%h busy=0 done=0", q, busy, done, RV);
        else passCount++;
        tick;
        @(negedge clock);
        reset = 1'b0; mode = M_HOLD;
        doneSeen = 0;
        for (int c = 0; c < 2 * WIDTH; c++) begin
            tick;
            if (done !== 1'b0) doneSeen++;
        end
        checkCount++;
        if (doneSeen != 0 || busy !== 1'b0 || q !== RV)
            $display("[TB] FAIL collide.after_reset got done_pulses=%0d busy=%b q=%h want 0 0 %h", doneSeen, busy, q, RV);
        else passCount++;
    endtask

    initial begin
        test_reset;
        test_shifts;
        test_rotate;
        test_serialise;
        test_stall;
        test_collisions;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
